// File: rtl/ahb2_slv_mem.sv
// AHB2 slave scratch memory: wait states, byte-lane writes, read-after-write forwarding.
// Define AHB2_SLV_MEM_ERR_RESP_EN to enable the two-cycle ERROR response for illegal transfers.
module ahb2_slv_mem #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hreadyi,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyo,
    output logic [1:0]            hresp
);

    localparam int unsigned NB        = DATA_WIDTH / 8;
    localparam int unsigned LB        = $clog2(NB);
    localparam int unsigned LBP1      = LB + 1;
    localparam int unsigned IW        = $clog2(DEPTH);
    localparam int unsigned ADDR_BITS = LB + IW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
    localparam logic [2:0] S_ERR1  = 3'd3;
    localparam logic [2:0] S_ERR2  = 3'd4;
`endif
    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES - 1);

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q;
    logic [NB-1:0]         mask_q;
    logic                  wr_q;

    logic                  accept_c;
    logic                  lat_c;
    logic                  hreadyo_c;
    logic                  commit_c;
    logic                  rd_load_c;
    logic                  fwd_c;
    logic [2:0]            size_eff_c;
    logic [LB:0]           nbytes_c;
    logic [LB-1:0]         off_al_c;
    logic [IW-1:0]         acc_idx_c;
    logic [IW-1:0]         rd_idx_c;
    logic [NB-1:0]         acc_mask_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  unused_c;
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
    logic                  illegal_c;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign accept_c = hsel & hreadyi & htrans[1];
    assign unused_c = ^{hburst, hprot, htrans[0], haddr};

    // Address decode: oversize clamps to full width, offset aligned down to the size boundary
    always_comb begin
        size_eff_c = (hsize > 3'(LB)) ? 3'(LB) : hsize;
        nbytes_c   = LBP1'(1) << size_eff_c;
        off_al_c   = haddr[LB-1:0] & ~LB'(nbytes_c - LBP1'(1));
        acc_idx_c  = haddr[ADDR_BITS-1:LB];
        acc_mask_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            acc_mask_c[i] = (LBP1'(i) >= {1'b0, off_al_c}) &&
                            (LBP1'(i) < ({1'b0, off_al_c} + nbytes_c));
        end
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
        illegal_c = (hsize > 3'(LB)) || (off_al_c != haddr[LB-1:0]) ||
                    ((haddr >> ADDR_BITS) != 32'd0);
`endif
    end

    // Next-state logic; IDLE, LAST and ERR2 all sample a new address phase
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_c     = 1'b0;
        hreadyo_c = 1'b1;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    lat_c = 1'b1;
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
                    if (illegal_c) begin
                        state_d = S_ERR1;
                    end else
`endif
                    if (WAIT_STATES == 0) begin
                        state_d = S_LAST;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
        endcase
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
        if ((state_d == S_WAIT) || (state_d == S_ERR1)) hreadyo_c = 1'b0;
`else
        if (state_d == S_WAIT) hreadyo_c = 1'b0;
`endif
    end

    // Read load on entry to LAST, forwarding a write completing in the same cycle
    always_comb begin
        commit_c  = (state_q == S_LAST) && wr_q;
        rd_idx_c  = (state_q == S_WAIT) ? idx_q : acc_idx_c;
        rd_load_c = (state_d == S_LAST) && (lat_c ? !hwrite : !wr_q);
        fwd_c     = commit_c && (idx_q == rd_idx_c);
        rd_word_c = mem[rd_idx_c];
        for (int unsigned i = 0; i < NB; i++) begin
            if (fwd_c && mask_q[i]) rd_word_c[8*i +: 8] = hwdata[8*i +: 8];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            hreadyo <= 1'b1;
            hrdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hreadyo <= hreadyo_c;
            if (lat_c) begin
                idx_q  <= acc_idx_c;
                mask_q <= acc_mask_c;
                wr_q   <= hwrite;
            end
            if (rd_load_c) hrdata <= rd_word_c;
        end
    end

`ifdef AHB2_SLV_MEM_ERR_RESP_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hresp <= 2'b00;
        end else begin
            hresp <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
        end
    end
`else
    assign hresp = 2'b00;
`endif

    // Storage is not reset; a write only lands in its LAST cycle
    always_ff @(posedge hclk) begin
        if (commit_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mask_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb2_slv_mem.sv
// Directed bench for ahb2_slv_mem: three instances (32b/0ws, 32b/3ws, 64b/16-deep).
module tb_ahb2_slv_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [63:0] hwdata;
    logic        hreadyi;

    logic [31:0] rdata0, rdata1;
    logic [63:0] rdata2;
    logic        rdy0, rdy1, rdy2;
    logic [1:0]  resp0, resp1, resp2;

    int          total;
    int          bad;
    logic [63:0] rd;
    logic [1:0]  rf, rl;
    int          wt;

    always #5 hclk = ~hclk;

    ahb2_slv_mem #(.DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata[31:0]), .hreadyi(hreadyi), .hrdata(rdata0), .hreadyo(rdy0), .hresp(resp0));

    ahb2_slv_mem #(.DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata[31:0]), .hreadyi(hreadyi), .hrdata(rdata1), .hreadyo(rdy1), .hresp(resp1));

    ahb2_slv_mem #(.DATA_WIDTH(64), .DEPTH(16), .WAIT_STATES(0)) u_dw64 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hreadyi(hreadyi), .hrdata(rdata2), .hreadyo(rdy2), .hresp(resp2));

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 3'b000;
        haddr  = 32'd0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic addr_phase(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel    = 3'b000;
        hsel[k] = 1'b1;
        haddr   = a;
        htrans  = 2'b10;
        hwrite  = w;
        hsize   = sz;
    endtask

    task automatic peek(input int k, output logic rdy, output logic [1:0] rsp, output logic [63:0] r);
        case (k)
            0:       begin rdy = rdy0; rsp = resp0; r = {32'd0, rdata0}; end
            1:       begin rdy = rdy1; rsp = resp1; r = {32'd0, rdata1}; end
            default: begin rdy = rdy2; rsp = resp2; r = rdata2; end
        endcase
    endtask

    // Single non-pipelined transfer; leaves data, first/last response and wait count in rd/rf/rl/wt
    task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [63:0] wd);
        logic        rdy;
        logic [1:0]  rsp;
        logic [63:0] r;
        addr_phase(k, a, w, sz);
        tick();
        idle_bus();
        hwdata = wd;
        wt = 0;
        peek(k, rdy, rsp, r);
        rf = rsp;
        while (!rdy && wt < 20) begin
            wt++;
            tick();
            peek(k, rdy, rsp, r);
        end
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("FAIL xfer_timeout: inst %0d addr %h hreadyo=%b want 1", k, a, rdy);
        end
        rl = rsp;
        rd = r;
        tick();
        hwdata = '0;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        idle_bus();
        hburst = 3'd0;
        hprot = 4'd0;
        hwdata = '0;
        hreadyi = 1'b1;
        tick();
        tick();
        total++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin bad++; $display("FAIL reset_ready: got %b want 111", {rdy0, rdy1, rdy2}); end
        total++; if ({resp0, resp1, resp2} !== 6'd0) begin bad++; $display("FAIL reset_resp: got %b want 000000", {resp0, resp1, resp2}); end
        total++; if (rdata0 !== 32'd0) begin bad++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
        total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        total++; if (rdata2 !== 64'd0) begin bad++; $display("FAIL reset_rdata2: got %h want 0", rdata2); end
        hreset = 1'b0;
        tick();
    endtask

    task automatic test_fwd();
        int lows = 0;
        addr_phase(0, 32'h10, 1'b1, 3'd2);
        tick();
        if (rdy0 !== 1'b1) lows++;
        hwdata = 64'hDEADBEEF;
        addr_phase(0, 32'h10, 1'b0, 3'd2);
        tick();
        if (rdy0 !== 1'b1) lows++;
        idle_bus();
        hwdata = '0;
        total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_word: got %h want deadbeef", rdata0); end
        total++; if (lows != 0) begin bad++; $display("FAIL fwd_ready: low cycles %0d want 0", lows); end
        tick();
        xfer(0, 32'h10, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_commit: got %h want deadbeef", rd[31:0]); end
        // byte write forwarded over the stored word
        xfer(0, 32'h14, 1'b1, 3'd2, 64'h11223344);
        addr_phase(0, 32'h15, 1'b1, 3'd0);
        tick();
        hwdata = 64'h0000AA00;
        addr_phase(0, 32'h14, 1'b0, 3'd2);
        tick();
        idle_bus();
        hwdata = '0;
        total++; if (rdata0 !== 32'h1122AA44) begin bad++; $display("FAIL fwd_merge: got %h want 1122aa44", rdata0); end
        tick();
    endtask

    task automatic test_byte_lane();
        xfer(0, 32'h10, 1'b1, 3'd2, 64'h11223344);
        xfer(0, 32'h13, 1'b1, 3'd0, 64'hAA000000);
        xfer(0, 32'h10, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'hAA223344) begin bad++; $display("FAIL byte_lane: got %h want aa223344", rd[31:0]); end
        xfer(0, 32'h12, 1'b1, 3'd1, 64'h55660000);
        xfer(0, 32'h10, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h55663344) begin bad++; $display("FAIL half_lane: got %h want 55663344", rd[31:0]); end
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        addr_phase(0, 32'h20, 1'b1, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        hwdata = 64'hA0A0A0A0; addr_phase(0, 32'h24, 1'b1, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        hwdata = 64'hB1B1B1B1; addr_phase(0, 32'h28, 1'b1, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        hwdata = 64'hC2C2C2C2; addr_phase(0, 32'h20, 1'b0, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        hwdata = '0;
        total++; if (rdata0 !== 32'hA0A0A0A0) begin bad++; $display("FAIL b2b_rd0: got %h want a0a0a0a0", rdata0); end
        addr_phase(0, 32'h24, 1'b0, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        total++; if (rdata0 !== 32'hB1B1B1B1) begin bad++; $display("FAIL b2b_rd1: got %h want b1b1b1b1", rdata0); end
        addr_phase(0, 32'h28, 1'b0, 3'd2); tick(); if (rdy0 !== 1'b1) lows++;
        total++; if (rdata0 !== 32'hC2C2C2C2) begin bad++; $display("FAIL b2b_rd2: got %h want c2c2c2c2", rdata0); end
        total++; if (lows != 0) begin bad++; $display("FAIL b2b_ready: low cycles %0d want 0", lows); end
        // two writes to one word complete in issue order
        addr_phase(0, 32'h30, 1'b1, 3'd2); tick();
        hwdata = 64'h0000AAAA; addr_phase(0, 32'h30, 1'b1, 3'd2); tick();
        hwdata = 64'h0000BBBB; idle_bus(); tick();
        hwdata = '0;
        xfer(0, 32'h30, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h0000BBBB) begin bad++; $display("FAIL waw_order: got %h want 0000bbbb", rd[31:0]); end
    endtask

    task automatic test_err_misaligned();
        xfer(0, 32'h0, 1'b1, 3'd2, 64'h01020304);
        xfer(0, 32'h1, 1'b1, 3'd1, 64'hCAFECAFE);
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
        total++; if (wt != 1) begin bad++; $display("FAIL mis_err_len: low cycles %0d want 1", wt); end
        total++; if (rf !== 2'b01) begin bad++; $display("FAIL mis_err_c1: hresp %b want 01", rf); end
        total++; if (rl !== 2'b01) begin bad++; $display("FAIL mis_err_c2: hresp %b want 01", rl); end
        xfer(0, 32'h0, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h01020304) begin bad++; $display("FAIL mis_unchanged: got %h want 01020304", rd[31:0]); end
`else
        total++; if (wt != 0) begin bad++; $display("FAIL mis_len: low cycles %0d want 0", wt); end
        total++; if (rl !== 2'b00) begin bad++; $display("FAIL mis_okay: hresp %b want 00", rl); end
        xfer(0, 32'h0, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h0102CAFE) begin bad++; $display("FAIL mis_align: got %h want 0102cafe", rd[31:0]); end
`endif
    endtask

    task automatic test_oversize();
        xfer(0, 32'h8, 1'b1, 3'd2, 64'h0BADF00D);
        xfer(0, 32'h8, 1'b1, 3'd3, 64'h5A5A5A5A);
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
        total++; if (rl !== 2'b01) begin bad++; $display("FAIL ovs_err: hresp %b want 01", rl); end
        xfer(0, 32'h8, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h0BADF00D) begin bad++; $display("FAIL ovs_unchanged: got %h want 0badf00d", rd[31:0]); end
`else
        total++; if (rl !== 2'b00) begin bad++; $display("FAIL ovs_okay: hresp %b want 00", rl); end
        xfer(0, 32'h8, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h5A5A5A5A) begin bad++; $display("FAIL ovs_full: got %h want 5a5a5a5a", rd[31:0]); end
`endif
    endtask

    task automatic test_range64();
        xfer(2, 32'h0, 1'b1, 3'd3, 64'h1111111122222222);
        xfer(2, 32'h78, 1'b1, 3'd3, 64'h0123456789ABCDEF);
        xfer(2, 32'h78, 1'b0, 3'd3, 64'd0);
        total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL r64_top: got %h want 0123456789abcdef", rd); end
        xfer(2, 32'h80, 1'b1, 3'd3, 64'hFEDCBA9876543210);
`ifdef AHB2_SLV_MEM_ERR_RESP_EN
        total++; if ((rf !== 2'b01) || (rl !== 2'b01) || (wt != 1)) begin
            bad++; $display("FAIL r64_err: resp %b/%b waits %0d want 01/01 1", rf, rl, wt);
        end
        xfer(2, 32'h0, 1'b0, 3'd3, 64'd0);
        total++; if (rd !== 64'h1111111122222222) begin bad++; $display("FAIL r64_word0: got %h want 1111111122222222", rd); end
`else
        total++; if (rl !== 2'b00) begin bad++; $display("FAIL r64_okay: hresp %b want 00", rl); end
        xfer(2, 32'h0, 1'b0, 3'd3, 64'd0);
        total++; if (rd !== 64'hFEDCBA9876543210) begin bad++; $display("FAIL r64_wrap: got %h want fedcba9876543210", rd); end
`endif
        xfer(2, 32'h78, 1'b0, 3'd3, 64'd0);
        total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL r64_top_kept: got %h want 0123456789abcdef", rd); end
    endtask

    task automatic test_wait();
        xfer(1, 32'h0, 1'b1, 3'd2, 64'hA5A5A5A5);
        total++; if (wt != 3) begin bad++; $display("FAIL ws_wr_len: low cycles %0d want 3", wt); end
        xfer(1, 32'h0, 1'b0, 3'd2, 64'd0);
        total++; if (wt != 3) begin bad++; $display("FAIL ws_rd_len: low cycles %0d want 3", wt); end
        total++; if (rl !== 2'b00) begin bad++; $display("FAIL ws_rd_resp: hresp %b want 00", rl); end
        total++; if (rd[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL ws_rd_data: got %h want a5a5a5a5", rd[31:0]); end
    endtask

    task automatic test_reset_mid();
        xfer(1, 32'h8, 1'b1, 3'd2, 64'h12345678);
        xfer(1, 32'h8, 1'b0, 3'd2, 64'd0);
        addr_phase(1, 32'h8, 1'b1, 3'd2);
        tick();
        idle_bus();
        hwdata = 64'h99999999;
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL rst_in_wait: hreadyo %b want 0", rdy1); end
        hreset = 1'b1;
        #1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_ready: hreadyo %b want 1", rdy1); end
        tick();
        hreset = 1'b0;
        hwdata = '0;
        total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata1); end
        tick();
        total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL rst_rdata_hold: got %h want 0", rdata1); end
        xfer(1, 32'h8, 1'b0, 3'd2, 64'd0);
        total++; if (rd[31:0] !== 32'h12345678) begin bad++; $display("FAIL rst_dropped_wr: got %h want 12345678", rd[31:0]); end
        total++; if (wt != 3) begin bad++; $display("FAIL rst_rd_len: low cycles %0d want 3", wt); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fwd();
        test_byte_lane();
        test_back_to_back();
        test_err_misaligned();
        test_oversize();
        test_range64();
        test_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb2_slv_mem.md
# ahb2_slv_mem

Parametrised AHB2 slave memory that sits behind the AHB2 slave-select fabric as a scratch/descriptor store for the accelerator. It generalises the 32-bit slave-side signal set to 32- or 64-bit data. It adds programmable wait states, byte-lane writes from `hsize`, read-after-write forwarding and a two-cycle ERROR response. All storage and control are local flops/array; `hburst` and `hprot` are accepted but do not alter behaviour, since every beat carries its own address.

## Interface
Parameters:
- `DATA_WIDTH`, 32 — bus data width; legal values 32 or 64.
- `DEPTH`, 1024 — number of `DATA_WIDTH` words; power of two, minimum 2.
- `WAIT_STATES`, 0 — data-phase wait cycles per legal transfer, 0..7.

Ports:
- `hclk` input 1 — clock; all logic on rising edge.
- `hreset` input 1 — reset, asynchronous and active-high.
- `hsel` input 1 — slave select.
- `haddr` input 32 — byte address.
- `htrans` input 2 — IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` input 1 — 1 = write.
- `hsize` input 3 — 0 = byte, 1 = half, 2 = word, 3 = dword.
- `hburst` input 3 — ignored.
- `hprot` input 4 — ignored.
- `hwdata` input `DATA_WIDTH` — write data, sampled in the completing data-phase cycle.
- `hreadyi` input 1 — bus-level HREADY.
- `hrdata` output `DATA_WIDTH` — read data.
- `hreadyo` output 1 — slave ready.
- `hresp` output 2 — OKAY=0, ERROR=1.

## Operation
Transfer acceptance:
- Accept = `hsel & hreadyi & htrans[1]`.
- On accept, the block latches `haddr`, `hwrite` and `hsize`.
- IDLE/BUSY, or `hsel`=0, get a zero-wait OKAY.

Lane and index computation:
- `LB` = log2(`DATA_WIDTH`/8).
- Word index = `haddr[LB+log2(DEPTH)-1:LB]`.
- Byte lanes are derived from `haddr[LB-1:0]` and `hsize`.

Illegal transfer (ERROR response):
- misaligned for its `hsize`, or
- `hsize` greater than `DATA_WIDTH`/8 bytes, or
- `haddr` ≥ `DEPTH*DATA_WIDTH/8`.

FSM states:
- **IDLE**: `hreadyo`=1, OKAY.
  - Legal accept → WAIT with `cnt`=`WAIT_STATES`-1, or → LAST when `WAIT_STATES`=0.
  - Illegal accept → ERR1.
- **WAIT**: `hreadyo`=0, OKAY; `cnt` decrements; `cnt`==0 → LAST.
- **LAST**: `hreadyo`=1, OKAY; the transfer completes.
  - Write: the enabled lanes of `hwdata` commit to the array at this cycle's edge.
  - A new accept in LAST follows the IDLE rules; otherwise → IDLE.
- **ERR1**: `hreadyo`=0, `hresp`=ERROR → ERR2.
- **ERR2**: `hreadyo`=1, `hresp`=ERROR. An accept in ERR2 follows the IDLE rules; otherwise → IDLE. Illegal writes never modify the array.

Read data path:
- `hrdata` is registered and loaded on the edge entering LAST for a read.
- It holds its value until the next read load, and outputs 0 after reset.
- Only the addressed lanes are meaningful.
- Read-after-write: if a read is accepted in the LAST cycle of a write to the same word, the loaded value merges the write's enabled `hwdata` lanes over the array word (forwarding).
- Write-after-write to the same word commits in order.

## Timing
- Reset: state IDLE, `hreadyo`=1, `hresp`=OKAY, `hrdata`=0, `cnt`=0. The array is not reset.
- Legal transfer: data phase lasts `WAIT_STATES`+1 cycles after the address phase, with `hreadyo` low for the first `WAIT_STATES` cycles.
- Error transfer: always exactly 2 data-phase cycles, regardless of `WAIT_STATES`.
- Back-to-back pipelined transfers sustain 1 transfer per `WAIT_STATES`+1 cycles.
- Reset asserted mid-transfer: immediate return to IDLE; a pending write is dropped.

## Configuration
- `AHB2_SLV_MEM_ERR_RESP_EN` defined:
  - illegal transfers produce the two-cycle ERROR described above.
- Undefined:
  - `hresp` is tied to OKAY; ERR1/ERR2 do not exist.
  - Out-of-range addresses wrap (the index uses only the low bits).
  - Misaligned addresses are aligned down to the `hsize` boundary.
  - Oversized `hsize` is treated as full width.

## Test plan
- `DATA_WIDTH`=32, `WAIT_STATES`=0: write word 0xDEADBEEF @0x10, then read @0x10 pipelined → `hrdata`=0xDEADBEEF in the cycle after the read address phase (forwarding path), `hreadyo` never low.
- `WAIT_STATES`=3: read @0x0 → `hreadyo` low for exactly 3 cycles, then high with OKAY.
- Byte write 0xAA @0x13 over word 0x11223344 @0x10 → read @0x10 returns 0xAA223344.
- Macro on: half-word access @0x1 → cycle 1 `hreadyo`=0/ERROR, cycle 2 `hreadyo`=1/ERROR, array unchanged. Same test with macro off → OKAY, and the write lands at @0x0.
- `DATA_WIDTH`=64, `DEPTH`=16: dword write @0x78, then access @0x80 → ERROR with macro on; with macro off it wraps to word 0.
- Assert `hreset` during WAIT of a write → `hreadyo`=1 next cycle, the target word is unchanged on readback, and `hrdata`=0 until the first read completes.
